ice40_himax_frame_sched: RTL and testbench

- Frame-level scheduler for the Himax human-detection pipeline.
- Decides which camera frames are captured and run through the ML engine; all others are skipped.
- Drives the clock-mask request that gates the video/ML clock tree between runs, and supervises ML completion with a watchdog.
- Sits between camera VSYNC, the video capture path and the ML engine; runs on the free-running oscillator clock.

---
 rtl/ice40_himax_frame_sched_pkg.sv | 19 +
 rtl/ice40_himax_frame_sched_if.sv | 23 ++
 rtl/ice40_himax_frame_sched_vsync_sync.sv | 33 +++
 rtl/ice40_himax_frame_sched.sv | 174 +++++++++++++++++
 tb/tb_ice40_himax_frame_sched.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ice40_himax_frame_sched_pkg.sv
// Shared types and constants for the Himax frame scheduler.
// The optional statistics block is enabled with HIMAX_SCHED_STATS_EN.
package himax_sched_pkg;

   localparam int unsigned SkipWDef  = 4;
   localparam int unsigned ToWDef    = 20;
   localparam int unsigned CntWDef   = 8;
   localparam int unsigned VsPeriodW = 24;

   typedef enum logic [2:0] {
      StInit    = 3'b000,
      StSkip    = 3'b001,
      StArm     = 3'b010,
      StCapture = 3'b011,
      StMlStart = 3'b100,
      StMlWait  = 3'b101
   } sched_state_e;

endpackage

// File: rtl/ice40_himax_frame_sched_if.sv
// Capture/ML handshake between the frame scheduler (slave side) and the video/ML pipeline.
interface himax_sched_if;

   logic i_vid_rdy;
   logic i_ml_done;
   logic o_vid_en;
   logic o_ml_start;

   modport slave (
      input  i_vid_rdy,
      input  i_ml_done,
      output o_vid_en,
      output o_ml_start
   );

   modport master (
      output i_vid_rdy,
      output i_ml_done,
      input  o_vid_en,
      input  o_ml_start
   );

endinterface

// File: rtl/ice40_himax_frame_sched_vsync_sync.sv
// Two-flop synchroniser plus registered rising-edge pulse; the pulse is 3 clocks after a pin edge.
module himax_vsync_sync (
   input  logic i_clk,
   input  logic resetn,
   input  logic i_async,
   output logic o_rise
);

   logic [1:0] sync_q, sync_d;
   logic       prev_q, prev_d;
   logic       rise_q, rise_d;

   always_comb begin
      sync_d = {sync_q[0], i_async};
      prev_d = sync_q[1];
      rise_d = sync_q[1] & ~prev_q;
   end

   always_ff @(posedge i_clk or negedge resetn) begin
      if (!resetn) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
      end
   end

   assign o_rise = rise_q;

endmodule

// File: rtl/ice40_himax_frame_sched.sv
// Frame scheduler: picks frames for capture + ML, gates clocks between runs, ML watchdog.
// Define HIMAX_SCHED_STATS_EN to add the vsync-period and watchdog-event counters.
module ice40_himax_frame_sched
   import himax_sched_pkg::*;
#(
   parameter int unsigned SKIP_W = SkipWDef,
   parameter int unsigned TO_W   = ToWDef,
   parameter int unsigned CNT_W  = CntWDef
) (
   input  logic                 i_clk,
   input  logic                 resetn,
   input  logic                 i_cam_vsync,
   input  logic                 i_init_done,
   input  logic                 i_load_done,
   input  logic [SKIP_W-1:0]    i_skip_n,
   input  logic                 i_force_run,
   input  logic [TO_W-1:0]      i_timeout,
   himax_sched_if.slave         sched_if,
   output logic                 o_mask_req,
   output logic                 o_ml_err,
   output logic [CNT_W-1:0]     o_run_cnt,
`ifdef HIMAX_SCHED_STATS_EN
   output logic [VsPeriodW-1:0] o_vs_period,
   output logic [CNT_W-1:0]     o_err_cnt,
`endif
   output logic [2:0]           o_state
);

   sched_state_e      state_q, state_d;
   logic [SKIP_W-1:0] skip_q, skip_d;
   logic [TO_W-1:0]   wdog_q, wdog_d;
   logic [CNT_W-1:0]  run_q, run_d;
   logic              err_q, err_d;
   logic              vid_en_q, vid_en_d;
   logic              start_q, start_d;
   logic              mask_q, mask_d;
   logic              vs_rise;
   logic              tmo_evt;

   himax_vsync_sync u_vsync (
      .i_clk   (i_clk),
      .resetn  (resetn),
      .i_async (i_cam_vsync),
      .o_rise  (vs_rise)
   );

   always_ff @(posedge i_clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StInit;
         skip_q   <= '0;
         wdog_q   <= '0;
         run_q    <= '0;
         err_q    <= 1'b0;
         vid_en_q <= 1'b0;
         start_q  <= 1'b0;
         mask_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         skip_q   <= skip_d;
         wdog_q   <= wdog_d;
         run_q    <= run_d;
         err_q    <= err_d;
         vid_en_q <= vid_en_d;
         start_q  <= start_d;
         mask_q   <= mask_d;
      end
   end

   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      wdog_d  = wdog_q;
      run_d   = run_q;
      err_d   = err_q;
      tmo_evt = 1'b0;
      unique case (state_q)
         StInit: begin
            if (i_init_done && i_load_done) state_d = StArm;
         end
         StArm: begin
            if (vs_rise) begin
               state_d = StCapture;
               skip_d  = i_skip_n;
            end
         end
         StCapture: begin
            if (sched_if.i_vid_rdy) state_d = StMlStart;
         end
         StMlStart: begin
            wdog_d  = '0;
            state_d = StMlWait;
         end
         StMlWait: begin
            if (wdog_q != '1) wdog_d = wdog_q + TO_W'(1);
            // Completion beats a timeout landing on the same cycle.
            if (sched_if.i_ml_done) begin
               run_d   = run_q + CNT_W'(1);
               state_d = (skip_q == '0 || i_force_run) ? StArm : StSkip;
            end else if (i_timeout != '0 && wdog_q == i_timeout - TO_W'(1)) begin
               err_d   = 1'b1;
               tmo_evt = 1'b1;
               state_d = StSkip;
            end
         end
         StSkip: begin
            // A zero count (only reachable after a timeout) behaves like the last skipped frame.
            if (i_force_run) begin
               state_d = StArm;
               skip_d  = '0;
            end else if (vs_rise) begin
               if (skip_q <= SKIP_W'(1)) begin
                  state_d = StArm;
                  skip_d  = '0;
               end else begin
                  skip_d = skip_q - SKIP_W'(1);
               end
            end
         end
         default: state_d = StInit;
      endcase
   end

   always_comb begin
      vid_en_d = (state_q == StCapture);
      start_d  = (state_q == StMlStart);
      mask_d   = (state_q == StSkip);
   end

   assign sched_if.o_vid_en   = vid_en_q;
   assign sched_if.o_ml_start = start_q;
   assign o_mask_req          = mask_q;
   assign o_ml_err            = err_q;
   assign o_run_cnt           = run_q;
   assign o_state             = state_q;

`ifdef HIMAX_SCHED_STATS_EN
   logic [VsPeriodW-1:0] per_cnt_q, per_cnt_d;
   logic [VsPeriodW-1:0] period_q, period_d;
   logic                 vs_seen_q, vs_seen_d;
   logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;

   always_comb begin
      per_cnt_d = per_cnt_q;
      period_d  = period_q;
      vs_seen_d = vs_seen_q;
      err_cnt_d = err_cnt_q;
      if (per_cnt_q != '1) per_cnt_d = per_cnt_q + VsPeriodW'(1);
      if (vs_rise) begin
         per_cnt_d = VsPeriodW'(1);
         vs_seen_d = 1'b1;
         if (vs_seen_q) period_d = per_cnt_q;
      end
      if (tmo_evt) err_cnt_d = err_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge i_clk or negedge resetn) begin
      if (!resetn) begin
         per_cnt_q <= '0;
         period_q  <= '0;
         vs_seen_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         per_cnt_q <= per_cnt_d;
         period_q  <= period_d;
         vs_seen_q <= vs_seen_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign o_vs_period = period_q;
   assign o_err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_ice40_himax_frame_sched.sv
// Self-checking bench for ice40_himax_frame_sched: directed scenarios plus randomized frames
// checked against a frame-level model (capture every skip+1 frames, force overrides).
module tb_ice40_himax_frame_sched;
   import himax_sched_pkg::*;

   localparam int SKIP_W = 4;
   localparam int TO_W   = 20;
   localparam int CNT_W  = 8;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              vs = 1'b0;
   logic              init_done = 1'b0;
   logic              load_done = 1'b0;
   logic              force_run = 1'b0;
   logic [SKIP_W-1:0] skip_n = '0;
   logic [TO_W-1:0]   timeout = '0;
   logic              mask;
   logic              err;
   logic [CNT_W-1:0]  run_cnt;
   logic [2:0]        state;
`ifdef HIMAX_SCHED_STATS_EN
   logic [23:0]       vs_period;
   logic [CNT_W-1:0]  err_cnt;
`endif

   himax_sched_if sif ();

   ice40_himax_frame_sched #(
      .SKIP_W (SKIP_W),
      .TO_W   (TO_W),
      .CNT_W  (CNT_W)
   ) dut (
      .i_clk       (clk),
      .resetn      (resetn),
      .i_cam_vsync (vs),
      .i_init_done (init_done),
      .i_load_done (load_done),
      .i_skip_n    (skip_n),
      .i_force_run (force_run),
      .i_timeout   (timeout),
      .sched_if    (sif.slave),
      .o_mask_req  (mask),
      .o_ml_err    (err),
      .o_run_cnt   (run_cnt),
`ifdef HIMAX_SCHED_STATS_EN
      .o_vs_period (vs_period),
      .o_err_cnt   (err_cnt),
`endif
      .o_state     (state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;
   int to_go  = 0;   // frames still to skip before the next capture
   int run_exp = 0;
   int starts = 0;

   always @(negedge clk) if (sif.o_ml_start === 1'b1) starts++;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: observed hang expected completion");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic reset_boot();
      resetn = 1'b0; init_done = 1'b0; load_done = 1'b0; force_run = 1'b0;
      sif.i_vid_rdy = 1'b0; sif.i_ml_done = 1'b0; vs = 1'b0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      init_done = 1'b1; load_done = 1'b1;
      repeat (2) @(negedge clk);
      to_go = 0; run_exp = 0;
   endtask

   task automatic wait_vid_en(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (sif.o_vid_en === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_start(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (sif.o_ml_start === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   // Vsync, capture handshake and prompt ML completion; state must be ARM on entry.
   task automatic start_run(input string tag);
      bit seen;
      vs = 1'b1;
      wait_vid_en(seen);
      vs = 1'b0;
      chk({tag, "_vid_en"}, 32'(seen), 32'd1);
      @(negedge clk);
      sif.i_vid_rdy = 1'b1;
      @(negedge clk);
      sif.i_vid_rdy = 1'b0;
      wait_start(seen);
      chk({tag, "_ml_start"}, 32'(seen), 32'd1);
   endtask

   task automatic frame(input logic [SKIP_W-1:0] sk, input bit frc, input string tag);
      bit seen;
      bit cap_exp;
      @(negedge clk);
      skip_n = sk; force_run = frc;
      repeat (3) @(negedge clk);
      cap_exp = frc || (to_go == 0);
      vs = 1'b1;
      wait_vid_en(seen);
      vs = 1'b0;
      chk({tag, "_capture"}, 32'(seen), 32'(cap_exp));
      if (seen) begin
         skip_n = SKIP_W'($urandom_range(0, 15));  // must not affect the sampled count
         repeat ($urandom_range(1, 5)) @(negedge clk);
         sif.i_vid_rdy = 1'b1;
         @(negedge clk);
         sif.i_vid_rdy = 1'b0;
         wait_start(seen);
         chk({tag, "_start"}, 32'(seen), 32'd1);
         @(negedge clk);
         chk({tag, "_start_width"}, 32'(sif.o_ml_start), 32'd0);
         repeat ($urandom_range(0, 20)) @(negedge clk);
         sif.i_ml_done = 1'b1;
         @(negedge clk);
         sif.i_ml_done = 1'b0;
         repeat (2) @(negedge clk);
         chk({tag, "_vid_off"}, 32'(sif.o_vid_en), 32'd0);
      end
      if (cap_exp) begin
         run_exp++;
         to_go = frc ? 0 : int'(sk);
      end else begin
         to_go--;
      end
      chk({tag, "_run_cnt"}, 32'(run_cnt), 32'(run_exp % (1 << CNT_W)));
      repeat (3) @(negedge clk);
      chk({tag, "_mask"}, 32'(mask), 32'(to_go != 0));
   endtask

   initial begin
      int s0;
      int n;
      bit seen;
      sif.i_vid_rdy = 1'b0;
      sif.i_ml_done = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_outs", {28'd0, sif.o_vid_en, sif.o_ml_start, mask, err}, 32'd0);
      chk("rst_run_cnt", 32'(run_cnt), 32'd0);
      chk("rst_state", 32'(state), 32'd0);

      // Boot: needs both init and load done
      resetn = 1'b1;
      @(negedge clk);
      init_done = 1'b1;
      repeat (4) @(negedge clk);
      chk("boot_wait_load", 32'(state), 32'(StInit));
      load_done = 1'b1;
      @(negedge clk);
      chk("boot_arm", 32'(state), 32'(StArm));
      chk("boot_mask", 32'(mask), 32'd0);
      to_go = 0; run_exp = 0;

      // Skip ratio: skip_n=3 over 12 frames -> 3 runs
      s0 = starts;
      for (int i = 0; i < 12; i++) frame(4'd3, 1'b0, "skip3");
      chk("skip3_starts", 32'(starts - s0), 32'd3);
      chk("skip3_run_cnt", 32'(run_cnt), 32'd3);

      // Randomized frames
      for (int i = 0; i < 30; i++)
         frame(SKIP_W'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0), "rand");

      // Watchdog
      reset_boot();
      timeout = TO_W'(100);
      skip_n = 4'd2;
      start_run("wdog");
      n = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         n++;
         if (err === 1'b1) break;
      end
      chk("wdog_latency", 32'(n), 32'd100);
      chk("wdog_state", 32'(state), 32'(StSkip));
      chk("wdog_run_cnt", 32'(run_cnt), 32'd0);
      repeat (20) @(negedge clk);
      chk("wdog_sticky", 32'(err), 32'd1);
      chk("wdog_mask", 32'(mask), 32'd1);
`ifdef HIMAX_SCHED_STATS_EN
      chk("wdog_err_cnt", 32'(err_cnt), 32'd1);
`endif

      // Done and timeout on the same cycle: done wins
      reset_boot();
      timeout = TO_W'(50);
      skip_n = 4'd0;
      start_run("coll");
      repeat (49) @(negedge clk);
      sif.i_ml_done = 1'b1;
      @(negedge clk);
      sif.i_ml_done = 1'b0;
      repeat (2) @(negedge clk);
      chk("coll_err", 32'(err), 32'd0);
      chk("coll_run_cnt", 32'(run_cnt), 32'd1);
      chk("coll_state", 32'(state), 32'(StArm));
      repeat (100) @(negedge clk);
      chk("coll_err_late", 32'(err), 32'd0);
      run_exp = 1; to_go = 0;
      timeout = '0;

      // Force run: mid-SKIP force goes to ARM on the next cycle, then every frame captures
      frame(4'd5, 1'b0, "pre_force");
      chk("pre_force_state", 32'(state), 32'(StSkip));
      force_run = 1'b1;
      @(negedge clk);
      chk("force_arm", 32'(state), 32'(StArm));
      frame(4'd5, 1'b1, "force1");
      frame(4'd5, 1'b1, "force2");
      frame(4'd5, 1'b0, "force_off");

      // Reset mid-run aborts asynchronously
      force_run = 1'b0;
      skip_n = 4'd1;
      frame(4'd0, 1'b1, "pre_rst");
      force_run = 1'b0;
      start_run("midrst");
      @(negedge clk);
      chk("midrst_pre_state", 32'(state), 32'(StMlWait));
      #2 resetn = 1'b0;
      #1;
      chk("midrst_outs", {28'd0, sif.o_vid_en, sif.o_ml_start, mask, err}, 32'd0);
      chk("midrst_run_cnt", 32'(run_cnt), 32'd0);
      chk("midrst_state", 32'(state), 32'(StInit));
      sif.i_vid_rdy = 1'b0;
      sif.i_ml_done = 1'b0;

`ifdef HIMAX_SCHED_STATS_EN
      // Vsync period of 5000 clocks
      @(negedge clk);
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      vs = 1'b1;
      repeat (4) @(negedge clk);
      vs = 1'b0;
      repeat (10) @(negedge clk);
      chk("period_first", 32'(vs_period), 32'd0);
      repeat (4986) @(negedge clk);
      vs = 1'b1;
      repeat (4) @(negedge clk);
      vs = 1'b0;
      repeat (6) @(negedge clk);
      chk("period_5000", 32'(vs_period), 32'd5000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
